// File: rtl/mash_pkg.sv
// Shared types and the DWA mask helper for the MASH 1-1 noise-cancel / element-select stage.
package mash_pkg;
  localparam int N_ELEM = 3;

  typedef logic [1:0] level_t;
  typedef logic [1:0] ptr_t;

  // Thermometer code of 'lvl' rotated left by 'p' within N_ELEM bits.
  function automatic logic [N_ELEM-1:0] dwa_mask(ptr_t p, level_t lvl);
    logic [N_ELEM-1:0]   therm;
    logic [2*N_ELEM-1:0] dbl;
    therm = 3'((4'd1 << lvl) - 4'd1);
    dbl   = {therm, therm} << p;
    return dbl[2*N_ELEM-1:N_ELEM];
  endfunction
endpackage

// File: rtl/mash_dwa_rotator.sv
// DWA pointer register with divider-free mod-3 advance and element mask generation.
module mash_dwa_rotator
  import mash_pkg::*;
#(
  parameter bit DWA_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_adv,
  input  level_t            i_level,
  output logic [N_ELEM-1:0] o_mask
);
  ptr_t       r_ptr;
  logic [2:0] w_sum;
  ptr_t       w_ptr_nxt;

  // p + level is at most 5, so one conditional subtract reduces it mod 3.
  always_comb begin
    w_sum = {1'b0, r_ptr} + {1'b0, i_level};
    if (w_sum >= 3'd3) w_sum = w_sum - 3'd3;
    w_ptr_nxt = w_sum[1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                 r_ptr <= '0;
    else if (i_adv && DWA_EN)  r_ptr <= w_ptr_nxt;
  end

  assign o_mask = DWA_EN ? dwa_mask(r_ptr, i_level) : dwa_mask(2'd0, i_level);
endmodule

// File: rtl/axis_mash_dwa.sv
// MASH 1-1 output combiner (y = c1 + c2 - c2[n-1]) driving three unit elements,
// registered AXI-Stream output with full backpressure.
module axis_mash_dwa
  import mash_pkg::*;
#(
  parameter bit DWA_EN = 1'b1
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic [1:0]  s_axis_data_tdata,
  input  logic        s_axis_data_tvalid,
  output logic        s_axis_data_tready,
  output logic [2:0]  m_axis_data_tdata,
  output logic [1:0]  m_axis_data_tlevel,
  output logic        m_axis_data_tvalid,
  input  logic        m_axis_data_tready
);
  logic              r_c2_d;
  logic              r_vld;
  logic [N_ELEM-1:0] r_mask;
  level_t            r_level;

  logic              w_c1, w_c2, w_acc;
  level_t            w_level;
  logic [N_ELEM-1:0] w_mask;

  assign w_c1 = s_axis_data_tdata[0];
  assign w_c2 = s_axis_data_tdata[1];

  // Offset level y+1 = c1 + c2 + (1 - c2_d); maximum is 3, so 2 bits never overflow.
  assign w_level = {1'b0, w_c1} + {1'b0, w_c2} + {1'b0, ~r_c2_d};

  assign s_axis_data_tready = !arst && (!r_vld || m_axis_data_tready);
  assign w_acc              = s_axis_data_tvalid && s_axis_data_tready;

  mash_dwa_rotator #(.DWA_EN(DWA_EN)) u_rot (
    .i_clk   (aclk),
    .i_rst   (arst),
    .i_adv   (w_acc),
    .i_level (w_level),
    .o_mask  (w_mask)
  );

  always_ff @(posedge aclk) begin
    if (arst) begin
      r_vld   <= 1'b0;
      r_mask  <= '0;
      r_level <= '0;
      r_c2_d  <= 1'b0;
    end else if (w_acc) begin
      r_vld   <= 1'b1;
      r_mask  <= w_mask;
      r_level <= w_level;
      r_c2_d  <= w_c2;
    end else if (m_axis_data_tready) begin
      r_vld   <= 1'b0;
    end
  end

  assign m_axis_data_tdata  = r_mask;
  assign m_axis_data_tlevel = r_level;
  assign m_axis_data_tvalid = r_vld;
endmodule

// File: doc/axis_mash_dwa.md
# axis_mash_dwa

Noise-cancellation and element-selection stage that sits directly downstream of the two cascaded first-order error-feedback modulators in the MASH 1-1 DAC path. Each AXI-Stream beat carries the two stage carries (c1, c2). The block forms the 4-level MASH output y = c1 + c2 − c2[n−1], then drives three unit DAC elements. By default it rotates the element selection with data-weighted averaging (DWA) to first-order shape element mismatch. Output is registered, with full AXI-Stream backpressure.

## Interface
- DWA_EN, default 1: 1 = DWA rotation; 0 = fixed thermometer code (elements 0..level−1).

Ports:
- aclk  in  1  clock; all logic on rising edge
- arst  in  1  reset, synchronous, active-high
- s_axis_data_tdata  in  2  bit0 = c1 (stage-1 carry), bit1 = c2 (stage-2 carry)
- s_axis_data_tvalid  in  1  input beat valid
- s_axis_data_tready  out  1  input beat accepted when high with tvalid
- m_axis_data_tdata  out  3  unit-element enables; bit k drives element k
- m_axis_data_tlevel  out  2  offset level 0..3 (= y + 1), sideband aligned with tdata
- m_axis_data_tvalid  out  1  output beat valid
- m_axis_data_tready  in  1  downstream accepts beat

## Operation
- Accept: acc = s_tvalid && s_tready.
- Level, unsigned 2 bit: level = c1 + c2 + (1 − c2_d), range 0..3, never overflows.
  - c2_d is a 1-bit register, reset 0.
  - c2_d loads c2 only on acc.
- DWA pointer p ∈ {0,1,2}, reset 0.
  - Mask enables elements p, p+1, …, p+level−1, all mod 3.
  - level 0 → 000; level 3 → 111.
  - On acc: p ← (p + level) mod 3. Compute without a divider: 3-bit sum, subtract 3 once if the sum is ≥3.
- DWA_EN=0: p is held at 0; mask = (1<<level)−1.
- The output register loads {mask, level} and sets m_tvalid on acc.
- s_tready = !arst && (!m_tvalid || m_tready), combinational.
  - An output beat may drain and a new beat load in the same cycle.
- State (c2_d, p, output register) changes only on acc or on a downstream drain. It never changes while stalled.
- Reset mid-operation: the in-flight output beat is dropped; c2_d, p and all outputs return to reset values on the next edge.

## Timing
- Reset values: m_tvalid=0, m_tdata=000, m_tlevel=0, p=0, c2_d=0. s_tready=0 while arst is high.
- Latency: input accepted at edge N → output valid after edge N, i.e. 1 cycle.
- Throughput: 1 beat per cycle when m_tready is held high.
- Backpressure rules:
  - m_tvalid && !m_tready holds m_tdata and m_tlevel stable.
  - s_tready is low in that cycle.
  - m_tvalid never drops without a handshake.
- DWA wrap: p wraps 2→0 with no idle cycle; level 3 leaves p unchanged.
- s_tvalid low: no state advance; the output drains normally.

## Structure
- Package mash_pkg holds:
  - localparam N_ELEM = 3
  - typedef level_t (logic [1:0])
  - typedef ptr_t (logic [1:0])
  - function dwa_mask(ptr_t, level_t), returning logic [2:0]
- One sub-module, mash_dwa_rotator: pointer register, mod-3 advance, mask generation. It has an advance-enable input driven by acc.
- The top level owns c2_d, the level adder, the output register and the handshake.

## Test plan
- Reset: assert arst for 3 cycles with s_tvalid=1 → s_tready=0, m_tvalid=0, m_tdata=000 throughout; s_tready=1 the first cycle after release.
- Level arithmetic (DWA_EN=0): (c1,c2) = (1,0),(1,1),(0,0),(0,1),(1,1) → m_tlevel 2,3,0,2,2 and m_tdata 011,111,000,011,011.
- DWA rotation: inputs (0,0)×3 then (1,0)×2 → tdata 001,010,100,011,101; p sequence 0→1→2→0→2→1.
- Backpressure: mid-stream, m_tready low for 4 cycles with s_tvalid high → m_tdata/m_tlevel stable, s_tready=0, p and c2_d frozen; on release, the output beat sequence equals the golden model with no loss or duplication.
- Random soak: 1000 random beats, random m_tready at 70% → on completion:
  - Σ(level−1) = Σc1 + c2 of the last accepted beat.
  - Per-element enable counts differ by ≤1 (DWA_EN=1).
  - Full-rate segments show 1 beat per cycle.
- Reset mid-stream: assert arst while m_tvalid=1 and p=2 → next cycle m_tvalid=0, p=0. The first beat after release, input (0,0), gives level 1 and mask 001.
